// File: rtl/keypad_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_matrix_scan
//  Description : 4x4 active-low matrix keypad scanner. Drives one column low
//                at a time, samples the synchronized rows, and debounces all
//                16 keys independently over whole scan frames. Emits a debounced
//                level vector and a one-cycle press pulse per key.
//                Optional auto-repeat of held keys: define KEYPAD_REPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_matrix_scan #(
    parameter int SCAN_DIV        = 5000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_RATE     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] key_pulse,
    output logic [15:0] key_state
);

    localparam int         c_cnt_w     = $clog2(SCAN_DIV);
    localparam logic [1:0] c_col0      = 2'd0;
    localparam logic [1:0] c_col1      = 2'd1;
    localparam logic [1:0] c_col2      = 2'd2;
    localparam logic [1:0] c_col3      = 2'd3;
    localparam logic [4:0] c_deb_limit = 5'(DEBOUNCE_FRAMES);

    // Reject parameter values the scan and debounce logic cannot honour
    generate
        if (SCAN_DIV < 4) begin : g_chk_scan_div
            $error("keypad_matrix_scan: SCAN_DIV must be >= 4");
        end
        if (DEBOUNCE_FRAMES < 2 || DEBOUNCE_FRAMES > 15) begin : g_chk_debounce
            $error("keypad_matrix_scan: DEBOUNCE_FRAMES must be 2..15");
        end
        if (REPEAT_DELAY < 1 || REPEAT_RATE < 1 || REPEAT_DELAY + REPEAT_RATE > 255) begin : g_chk_repeat
            $error("keypad_matrix_scan: REPEAT_DELAY + REPEAT_RATE must fit in 8 bits");
        end
    endgenerate

    logic [3:0]         r_row_meta;
    logic [3:0]         r_row_sync;
    logic [c_cnt_w-1:0] r_scan_cnt;
    logic [1:0]         r_col;
    logic [3:0]         r_col_out;
    logic [15:0]        r_raw;
    logic               r_frame_done;
    logic [15:0]        r_key_state;
    logic [15:0]        r_key_pulse;
    logic [3:0]         r_cnt [16];

    logic               w_scan_last;
    logic [15:0]        w_state_nxt;
    logic [15:0]        w_press;
    logic [3:0]         w_cnt_nxt [16];

`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] c_rpt_delay  = 8'(REPEAT_DELAY);
    localparam logic [7:0] c_rpt_period = 8'(REPEAT_DELAY + REPEAT_RATE);
    logic [7:0]         r_rpt_cnt;
    logic [7:0]         w_rpt_inc;
    assign w_rpt_inc = r_rpt_cnt + 8'd1;
`endif

    assign w_scan_last = (r_scan_cnt == c_cnt_w'(SCAN_DIV - 1));
    assign col_out     = r_col_out;
    assign key_pulse   = r_key_pulse;
    assign key_state   = r_key_state;

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row_meta <= 4'h0;
            r_row_sync <= 4'h0;
        end else begin
            r_row_meta <= row_in;
            r_row_sync <= r_row_meta;
        end
    end

    // Column scan FSM: hold each column for SCAN_DIV cycles, sample rows at the end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan_cnt   <= '0;
            r_col        <= c_col0;
            r_col_out    <= 4'b1110;
            r_raw        <= 16'h0000;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_scan_last) begin
                r_scan_cnt <= '0;
                case (r_col)
                    c_col0: begin
                        r_raw[3:0]  <= ~r_row_sync;
                        r_col       <= c_col1;
                        r_col_out   <= 4'b1101;
                    end
                    c_col1: begin
                        r_raw[7:4]  <= ~r_row_sync;
                        r_col       <= c_col2;
                        r_col_out   <= 4'b1011;
                    end
                    c_col2: begin
                        r_raw[11:8] <= ~r_row_sync;
                        r_col       <= c_col3;
                        r_col_out   <= 4'b0111;
                    end
                    c_col3: begin
                        // Last column of the frame: raw is now complete
                        r_raw[15:12] <= ~r_row_sync;
                        r_col        <= c_col0;
                        r_col_out    <= 4'b1110;
                        r_frame_done <= 1'b1;
                    end
                    default: begin
                        r_col     <= c_col0;
                        r_col_out <= 4'b1110;
                    end
                endcase
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

    // Per-key debounce decision: count consecutive disagreeing frames
    always_comb begin
        w_state_nxt = r_key_state;
        for (int k = 0; k < 16; k++) begin
            w_cnt_nxt[k] = r_cnt[k];
            if (r_raw[k] == r_key_state[k]) begin
                w_cnt_nxt[k] = 4'd0;
            end else if (({1'b0, r_cnt[k]} + 5'd1) == c_deb_limit) begin
                w_state_nxt[k] = ~r_key_state[k];
                w_cnt_nxt[k]   = 4'd0;
            end else begin
                w_cnt_nxt[k] = r_cnt[k] + 4'd1;
            end
        end
        w_press = w_state_nxt & ~r_key_state;
    end

    // Commit debounce results once per frame and generate press pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_state <= 16'h0000;
            r_key_pulse <= 16'h0000;
            for (int k = 0; k < 16; k++) begin
                r_cnt[k] <= 4'd0;
            end
`ifdef KEYPAD_REPEAT_EN
            r_rpt_cnt <= 8'd0;
`endif
        end else begin
            r_key_pulse <= 16'h0000;
            if (r_frame_done) begin
                r_key_state <= w_state_nxt;
                r_cnt       <= w_cnt_nxt;
`ifdef KEYPAD_REPEAT_EN
                // Shared repeat timer restarts on any new press or when nothing is held
                if ((|w_press) || (w_state_nxt == 16'h0000)) begin
                    r_rpt_cnt   <= 8'd0;
                    r_key_pulse <= w_press;
                end else if (w_rpt_inc == c_rpt_delay) begin
                    r_rpt_cnt   <= w_rpt_inc;
                    r_key_pulse <= w_state_nxt;
                end else if (w_rpt_inc == c_rpt_period) begin
                    r_rpt_cnt   <= c_rpt_delay;
                    r_key_pulse <= w_state_nxt;
                end else begin
                    r_rpt_cnt   <= w_rpt_inc;
                end
`else
                r_key_pulse <= w_press;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_matrix_scan
//  Description : Self-checking bench for keypad_matrix_scan with a keypad
//                model and a frame-level reference model of debounce/repeat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scan;

    localparam int SCAN_DIV = 8;
    localparam int DEB      = 4;
    localparam int RD       = 16;
    localparam int RR       = 4;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] key_pulse;
    logic [15:0] key_state;

    logic [15:0] keys = 16'h0000;

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state
    int          t = 0;
    bit          chk_en = 1'b0;
    bit [15:0]   m_state = '0;
    bit [15:0]   m_pulse = '0;
    int          m_cnt [16];
    int          m_rpt = 0;
    int          pulse_cnt [16];
    logic [15:0] last_pulse = '0;

    keypad_matrix_scan #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_pulse (key_pulse),
        .key_state (key_state)
    );

    always #5 clk = ~clk;

    // Keypad: a closed key pulls its row low while its column is driven low
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (col_out[c] == 1'b0 && keys[c*4 + r]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // One debounce evaluation on the closed-key set seen during the last frame
    task automatic model_frame();
        bit [15:0] old_state;
        old_state = m_state;
        for (int k = 0; k < 16; k++) begin
            if (keys[k] == m_state[k]) begin
                m_cnt[k] = 0;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == DEB) begin
                    m_state[k] = ~m_state[k];
                    m_cnt[k]   = 0;
                end
            end
        end
        m_pulse = m_state & ~old_state;
`ifdef KEYPAD_REPEAT_EN
        if (m_pulse != 0 || m_state == 0) begin
            m_rpt = 0;
        end else begin
            m_rpt = m_rpt + 1;
            if (m_rpt == RD) begin
                m_pulse = m_state;
            end else if (m_rpt == RD + RR) begin
                m_pulse = m_state;
                m_rpt   = RD;
            end
        end
`endif
    endtask

    // Model timeline: t counts cycles since reset release; results of each
    // frame become visible one cycle into the following frame
    always @(posedge clk) begin
        if (!rst_n) begin
            t       = 0;
            chk_en  = 1'b1;
            m_state = '0;
            m_pulse = '0;
            m_rpt   = 0;
            for (int k = 0; k < 16; k++) m_cnt[k] = 0;
        end else begin
            t       = t + 1;
            m_pulse = '0;
            if (t >= FRAME + 1 && (t % FRAME) == 1) model_frame();
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        logic [3:0] ec;
        if (chk_en) begin
            ec = 4'hF;
            ec[(t / SCAN_DIV) % 4] = 1'b0;
            check("col_out", {12'h000, col_out}, {12'h000, ec});
            check("key_state", key_state, m_state);
            check("key_pulse", key_pulse, m_pulse);
            if (key_pulse != 16'h0000) last_pulse = key_pulse;
            for (int k = 0; k < 16; k++) begin
                if (key_pulse[k] === 1'b1) pulse_cnt[k] = pulse_cnt[k] + 1;
            end
        end
    end

    task automatic clear_counts();
        for (int k = 0; k < 16; k++) pulse_cnt[k] = 0;
        last_pulse = '0;
    endtask

    // Advance to two cycles into the next frame, where keys may change safely
    task automatic next_frame_start();
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while ((t % FRAME) != 2 && guard < 2 * FRAME);
        if (guard >= 2 * FRAME) check("frame_sync_timeout", 16'h0001, 16'h0000);
    endtask

    task automatic frames(input int n);
        repeat (n) next_frame_start();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            pulse_cnt[k] = 0;
            m_cnt[k]     = 0;
        end

        // 1. Reset and column walk (walk checked by the monitor)
        do_reset();
        check("rst_col_out", {12'h000, col_out}, 16'h000E);
        check("rst_key_state", key_state, 16'h0000);
        check("rst_key_pulse", key_pulse, 16'h0000);
        frames(2);

        // 2. Single press of key 6 for 10 frames
        clear_counts();
        keys = 16'h0040;
        frames(10);
        check("s2_state_held", key_state, 16'h0040);
        keys = 16'h0000;
        frames(6);
        check("s2_pulse_count", 16'(pulse_cnt[6]), 16'd1);
        check("s2_last_pulse", last_pulse, 16'h0040);
        check("s2_released", key_state, 16'h0000);

        // 3. Bouncing key 9 then stable; then a too-short closure
        clear_counts();
        keys = 16'h0200; frames(1);
        keys = 16'h0000; frames(1);
        keys = 16'h0200; frames(7);
        keys = 16'h0000; frames(6);
        check("s3_bounce_pulses", 16'(pulse_cnt[9]), 16'd1);
        clear_counts();
        keys = 16'h0200; frames(3);
        keys = 16'h0000; frames(5);
        check("s3_short_pulses", 16'(pulse_cnt[9]), 16'd0);
        check("s3_short_state", key_state, 16'h0000);

        // 4. Keys 0 and 15 together
        clear_counts();
        keys = 16'h8001;
        frames(6);
        check("s4_state", key_state, 16'h8001);
        check("s4_pulse", last_pulse, 16'h8001);
        check("s4_count0", 16'(pulse_cnt[0]), 16'd1);
        keys = 16'h0000;
        frames(6);

        // 5. Reset during debounce of key 6
        keys = 16'h0040;
        frames(2);
        do_reset();
        clear_counts();
        while (t < 4 * FRAME) begin
            @(posedge clk);
            #1;
        end
        check("s5_no_early_pulse", 16'(pulse_cnt[6]), 16'd0);
        repeat (4) @(posedge clk);
        #1;
        check("s5_pulse_after", 16'(pulse_cnt[6]), 16'd1);
        keys = 16'h0000;
        frames(6);

        // 6. Long hold of key 3 (auto-repeat when enabled)
        clear_counts();
        next_frame_start();
        keys = 16'h0008;
        frames(30);
        keys = 16'h0000;
        frames(6);
`ifdef KEYPAD_REPEAT_EN
        check("s6_repeat_count", 16'(pulse_cnt[3]), 16'd5);
`else
        check("s6_single_pulse", 16'(pulse_cnt[3]), 16'd1);
`endif

        // Randomized key activity checked by the reference model
        repeat (40) begin
            next_frame_start();
            if ($urandom_range(0, 2) == 0) begin
                keys = 16'(1 << $urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) keys = keys | 16'(1 << $urandom_range(0, 15));
            end else if ($urandom_range(0, 3) == 0) begin
                keys = 16'h0000;
            end
        end
        keys = 16'h0000;
        frames(6);
        check("final_state", key_state, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
